mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Sequences and shares a single data-memory port between the instruction-fetch requester (I) and the load/store requester (D).
- Converts level-held requests into one registered memory transaction at a time, returns read data with a one-cycle done pulse, and validates alignment and length.
- Sits between the fetch/memory stages and the DPI-backed memory model.
- Arbitration and one-in-flight sequencing let the core move from single-cycle to multi-cycle or stalled memory.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 16, max cycles waiting for mem_ready before aborting with error; 0 = never time out

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- i_req  in  1  fetch request, held until i_done
- i_addr  in  ADDR_W  fetch address (word access)
- i_done  out  1  one-cycle completion pulse
- i_rdata  out  DATA_W  fetched word, valid with i_done
- i_err  out  1  error qualifier, valid with i_done
- d_req  in  1  load/store request, held until d_done
- d_we  in  1  1 = store, 0 = load
- d_len  in  3  byte count: 1, 2 or 4
- d_addr  in  ADDR_W  byte address
- d_wdata  in  DATA_W  store data, low d_len bytes significant
- d_done  out  1  one-cycle completion pulse
- d_rdata  out  DATA_W  raw loaded word, valid with d_done; 0 for stores
- d_err  out  1  error qualifier, valid with d_done
- mem_req  out  1  memory request, held until mem_ready
- mem_we  out  1  write enable
- mem_len  out  3  byte count
- mem_addr  out  ADDR_W  address
- mem_wdata  out  DATA_W  write data
- mem_ready  in  1  memory accepted/completed this cycle
- mem_rdata  in  DATA_W  read data, valid when mem_ready & !mem_we

Behaviour:
- Reset:
  - Synchronous reset; rst has priority over everything.
  - State IDLE.
  - All outputs 0.
  - Latched request fields cleared.
  - Timeout counter cleared.
  - Reset during BUSY abandons the transaction: mem_req is 0 the cycle after the reset edge and no done is issued.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - If any request is high, select an owner (see arbitration) and latch its fields.
  - Fetch fields are forced to we=0, len=4.
  - Validity check:
    - len in {1,2,4}.
    - len=2 requires addr[0]=0.
    - len=4 requires addr[1:0]=0.
  - Valid request: go to BUSY; mem_* is driven from the latched fields, with mem_req=1 starting the next cycle.
  - Invalid request: no memory access; go to DONE with err=1 and rdata=0.
- BUSY:
  - mem_req=1 and all mem_* fields stay stable until mem_ready.
  - On mem_ready: drop mem_req next cycle; latch mem_rdata into the owner's rdata (0 for writes); go to DONE with err=0.
  - Counter increments each BUSY cycle without mem_ready.
  - If TIMEOUT>0 and the counter reaches TIMEOUT-1 without mem_ready: drop mem_req; go to DONE with err=1 and rdata=0.
- DONE:
  - Exactly one cycle.
  - Owner's done=1 and err as determined.
  - All requests are ignored in this cycle; the requester deasserts req here or issues a new one.
  - Next state IDLE.
- Done, rdata and err are registered; the non-owner's outputs stay 0.
- Latency:
  - Minimum with mem_ready in the first BUSY cycle: req@T0, mem_req@T1, done@T2, next grant evaluated @T3.
  - Throughput is one transaction per 3 cycles maximum.
- Arbitration (macro off): fixed priority, D over I. Simultaneous i_req and d_req in IDLE grants D.
- Requests are sampled only in IDLE; a request rising during BUSY or DONE waits.
- Requester-side inputs changing while granted are ignored, because fields are latched.

Optional Feature:
- Macro: MEM_PORT_ARB_RR_EN.
- Defined:
  - Round-robin arbitration using a 1-bit last_owner register, reset to I.
  - On simultaneous requests, grant the requester that was not last_owner.
  - last_owner updates on every grant, including invalid-request grants.
- Undefined: fixed D-over-I priority as above; no last_owner register is present.

Test Plan:
- Fetch only: i_req=1, i_addr=0x80000000, mem_ready=1 at first BUSY cycle, mem_rdata=0x00000413 -> mem_req high exactly 1 cycle with mem_addr=0x80000000, mem_len=4, mem_we=0; i_done pulse at T2 with i_rdata=0x00000413, i_err=0.
- Store byte with 3-cycle memory stall: d_req=1, d_we=1, d_len=1, d_addr=0x80001003, d_wdata=0x000000AB; mem_ready asserted in 3rd BUSY cycle -> mem_* stable for 3 cycles; d_done pulse one cycle after mem_ready; d_rdata=0, d_err=0.
- Misaligned: d_len=4, d_addr=0x80000002 -> mem_req never asserted; d_done=1, d_err=1 at T1. Repeat with d_len=3 at aligned address -> same response.
- Contention: i_req and d_req both high continuously, mem_ready always 1:
  - Macro off -> D, D, D grants; I never granted while d_req stays high.
  - Macro on -> grant order D, I, D, I.
- Timeout: TIMEOUT=16, mem_ready held 0 -> mem_req high exactly 16 cycles, then drops; owner done=1, err=1, rdata=0.
- Reset mid-BUSY: rst=1 on 2nd BUSY cycle -> next cycle mem_req=0, no done pulse; new i_req after rst release is serviced normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch (I)
// and load/store (D). Requests are level-held. One transaction is in flight
// at a time. Each transaction ends with a one-cycle registered done pulse
// that carries rdata and err.
// Optional feature macro: MEM_PORT_ARB_RR_EN
//   When it is defined, round-robin arbitration is used on contention.
//   When it is undefined, D has fixed priority over I.
module mem_port_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              i_done,
   output logic [DATA_W-1:0] i_rdata,
   output logic              i_err,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [2:0]        d_len,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_done,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_err,
   output logic              mem_req,
   output logic              mem_we,
   output logic [2:0]        mem_len,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ready,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t              state, state_n;
   logic                own_d;       // owner of the transaction in flight
   logic                gnt_d;       // D wins this IDLE-cycle arbitration
   logic                any_req;
   logic                req_ok;
   logic                timeout_hit;
   logic [CNT_W-1:0]    cnt;
   logic                sel_we;
   logic [2:0]          sel_len;
   logic [ADDR_W-1:0]   sel_addr;
   logic [DATA_W-1:0]   sel_wdata;

   assign any_req = i_req | d_req;

`ifdef MEM_PORT_ARB_RR_EN
   logic last_d;   // 1: D owned the last grant, 0: I owned it

   // On contention, grant the side that did not own the last grant
   assign gnt_d = d_req & (~i_req | ~last_d);

   // Track the last owner on every grant, including grants of invalid requests
   always_ff @(posedge clk) begin
      if (rst)
         last_d <= 1'b0;
      else if (state == IDLE && any_req)
         last_d <= gnt_d;
   end
`else
   // Fixed priority: D over I
   assign gnt_d = d_req;
`endif

   // Select the winner's fields. Fetch is always a 4-byte read
   always_comb begin
      sel_we    = 1'b0;
      sel_len   = 3'd4;
      sel_addr  = i_addr;
      sel_wdata = '0;
      if (gnt_d) begin
         sel_we    = d_we;
         sel_len   = d_len;
         sel_addr  = d_addr;
         sel_wdata = d_wdata;
      end
   end

   // Length and natural-alignment check on the selected request
   always_comb begin
      req_ok = 1'b0;
      case (sel_len)
         3'd1:    req_ok = 1'b1;
         3'd2:    req_ok = ~sel_addr[0];
         3'd4:    req_ok = (sel_addr[1:0] == 2'b00);
         default: req_ok = 1'b0;
      endcase
   end

   // Abort once the counter reaches TIMEOUT-1 with no mem_ready
   assign timeout_hit = (TIMEOUT > 0) && !mem_ready && (cnt == CNT_W'(TIMEOUT - 1));

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   // Next-state logic
   always_comb begin
      state_n = state;
      case (state)
         IDLE: if (any_req) state_n = req_ok ? BUSY : DONE;
         BUSY: if (mem_ready || timeout_hit) state_n = DONE;
         DONE: state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // Latch the request, drive the memory port and register the completion
   always_ff @(posedge clk) begin
      if (rst) begin
         own_d     <= 1'b0;
         cnt       <= '0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_len   <= 3'd0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         i_done    <= 1'b0;
         i_err     <= 1'b0;
         i_rdata   <= '0;
         d_done    <= 1'b0;
         d_err     <= 1'b0;
         d_rdata   <= '0;
      end else begin
         i_done  <= 1'b0;
         i_err   <= 1'b0;
         i_rdata <= '0;
         d_done  <= 1'b0;
         d_err   <= 1'b0;
         d_rdata <= '0;
         case (state)
            IDLE: begin
               if (any_req) begin
                  own_d     <= gnt_d;
                  mem_we    <= sel_we;
                  mem_len   <= sel_len;
                  mem_addr  <= sel_addr;
                  mem_wdata <= sel_wdata;
                  cnt       <= '0;
                  mem_req   <= req_ok;
                  // An invalid request completes at once with an error
                  if (!req_ok) begin
                     if (gnt_d) begin
                        d_done <= 1'b1;
                        d_err  <= 1'b1;
                     end else begin
                        i_done <= 1'b1;
                        i_err  <= 1'b1;
                     end
                  end
               end
            end
            BUSY: begin
               if (mem_ready) begin
                  mem_req <= 1'b0;
                  if (own_d) begin
                     d_done  <= 1'b1;
                     d_rdata <= mem_we ? '0 : mem_rdata;
                  end else begin
                     i_done  <= 1'b1;
                     i_rdata <= mem_rdata;
                  end
               end else if (timeout_hit) begin
                  mem_req <= 1'b0;
                  if (own_d) begin
                     d_done <= 1'b1;
                     d_err  <= 1'b1;
                  end else begin
                     i_done <= 1'b1;
                     i_err  <= 1'b1;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter. It runs directed cases from the
// test plan, then randomized transactions. Both are checked against a
// transaction-level model of grant, validity, latency and response.
module tb_mem_port_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 16;

`ifdef MEM_PORT_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          i_req = 1'b0;
   logic [AW-1:0] i_addr = '0;
   logic          i_done;
   logic [DW-1:0] i_rdata;
   logic          i_err;
   logic          d_req = 1'b0;
   logic          d_we = 1'b0;
   logic [2:0]    d_len = 3'd0;
   logic [AW-1:0] d_addr = '0;
   logic [DW-1:0] d_wdata = '0;
   logic          d_done;
   logic [DW-1:0] d_rdata;
   logic          d_err;
   logic          mem_req;
   logic          mem_we;
   logic [2:0]    mem_len;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          mem_ready = 1'b0;
   logic [DW-1:0] mem_rdata = '0;

   int total = 0;
   int bad   = 0;
   bit last_d = 1'b0;   // model: last grant went to D

   always #5 clk = ~clk;

   mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata), .i_err(i_err),
      .d_req(d_req), .d_we(d_we), .d_len(d_len), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_done(d_done), .d_rdata(d_rdata), .d_err(d_err),
      .mem_req(mem_req), .mem_we(mem_we), .mem_len(mem_len), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
   );

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, act, exp);
      end
   endtask

   // Issue one transaction and check it cycle by cycle against the model.
   // stall = the mem_req cycle in which memory answers (large = never).
   task automatic run_txn(input string tag, input bit ir, input logic [31:0] ia,
                          input bit dr, input bit we, input logic [2:0] len,
                          input logic [31:0] da, input logic [31:0] wd,
                          input int stall, input logic [31:0] rd);
      bit own_d, ok, ewe, eerr;
      logic [2:0]  elen;
      logic [31:0] eaddr, erd;
      int exp_m, exp_done, mcyc, done_at;
      // model: arbitration
      if (ir && dr) own_d = RR ? !last_d : 1'b1;
      else          own_d = dr;
      last_d = own_d;
      ewe   = own_d ? we : 1'b0;
      elen  = own_d ? len : 3'd4;
      eaddr = own_d ? da : ia;
      ok = (elen == 1) || (elen == 2 && eaddr % 2 == 0) || (elen == 4 && eaddr % 4 == 0);
      if (!ok) begin
         exp_m = 0; exp_done = 1; eerr = 1; erd = 0;
      end else if (TO > 0 && stall > TO) begin
         exp_m = TO; exp_done = TO + 1; eerr = 1; erd = 0;
      end else begin
         exp_m = stall; exp_done = stall + 1; eerr = 0; erd = ewe ? 32'h0 : rd;
      end

      @(posedge clk); #1;
      i_req = ir; i_addr = ia;
      d_req = dr; d_we = we; d_len = len; d_addr = da; d_wdata = wd;
      mem_ready = 1'b0;
      mcyc = 0; done_at = 0;
      for (int c = 1; c <= 40 && done_at == 0; c++) begin
         @(posedge clk); #1;
         // requester inputs may wander once granted
         d_addr = $urandom; i_addr = $urandom; d_len = 3'($urandom); d_we = 1'($urandom);
         if (mem_req) begin
            mcyc++;
            chk({tag, "_we"}, mem_we, ewe);
            chk({tag, "_len"}, mem_len, elen);
            chk({tag, "_addr"}, mem_addr, eaddr);
            if (own_d) chk({tag, "_wdata"}, mem_wdata, wd);
            mem_ready = (mcyc == stall);
            mem_rdata = (mcyc == stall) ? rd : $urandom;
         end else begin
            mem_ready = 1'b0;
            mem_rdata = $urandom;
         end
         if (i_done || d_done) begin
            done_at = c;
            chk({tag, "_owner_d"}, d_done, own_d);
            chk({tag, "_owner_i"}, i_done, !own_d);
            chk({tag, "_err"}, own_d ? d_err : i_err, eerr);
            chk({tag, "_rdata"}, own_d ? d_rdata : i_rdata, erd);
            chk({tag, "_other"}, own_d ? {i_err, i_rdata} : {d_err, d_rdata}, 0);
            i_req = 1'b0; d_req = 1'b0;
         end
      end
      chk({tag, "_done_cyc"}, done_at, exp_done);
      chk({tag, "_memcyc"}, mcyc, exp_m);
      i_req = 1'b0; d_req = 1'b0; mem_ready = 1'b0;
      @(posedge clk); #1;
      chk({tag, "_pulse"}, {i_done, d_done, mem_req}, 0);
   endtask

   initial begin
      int n, sel, stall;
      logic [2:0] lens [8];
      lens = '{3'd1, 3'd2, 3'd4, 3'd1, 3'd2, 3'd4, 3'd3, 3'd0};

      repeat (2) @(posedge clk);
      #1;
      chk("rst_out", {i_done, i_err, i_rdata, d_done, d_err, d_rdata}, 0);
      chk("rst_mem", {mem_req, mem_we, mem_len, mem_addr, mem_wdata}, 0);
      rst = 1'b0;

      // directed cases
      run_txn("fetch", 1, 32'h8000_0000, 0, 0, 3'd0, 0, 0, 1, 32'h0000_0413);
      run_txn("sb_stall", 0, 0, 1, 1, 3'd1, 32'h8000_1003, 32'h0000_00AB, 3, 32'hDEAD_BEEF);
      run_txn("misalign", 0, 0, 1, 0, 3'd4, 32'h8000_0002, 0, 1, 32'h1234_5678);
      run_txn("len3", 0, 0, 1, 0, 3'd3, 32'h8000_0000, 0, 1, 32'h1234_5678);
      run_txn("lh_ok", 0, 0, 1, 0, 3'd2, 32'h8000_0006, 0, 2, 32'hCAFE_F00D);
      run_txn("timeout", 0, 0, 1, 0, 3'd4, 32'h8000_0010, 0, 999, 32'h5555_5555);
      run_txn("to_edge", 1, 32'h8000_0020, 0, 0, 3'd0, 0, 0, TO, 32'hA5A5_A5A5);

      // contention: both held, memory always ready
      @(posedge clk); #1;
      i_req = 1; i_addr = 32'h8000_0300;
      d_req = 1; d_we = 0; d_len = 3'd4; d_addr = 32'h8000_0200;
      n = 0;
      for (int c = 0; c < 60 && n < 6; c++) begin
         @(posedge clk); #1;
         if (i_done || d_done) begin
            bit exp_d;
            exp_d = RR ? !last_d : 1'b1;
            chk("arb_owner", {i_done, d_done}, {!exp_d, exp_d});
            last_d = exp_d;
            n++;
         end
         mem_ready = mem_req;
         mem_rdata = $urandom;
      end
      chk("arb_count", n, 6);
      i_req = 0; d_req = 0; mem_ready = 0;
      @(posedge clk); #1;

      // reset during BUSY
      @(posedge clk); #1;
      d_req = 1; d_we = 0; d_len = 3'd4; d_addr = 32'h8000_0100;
      @(posedge clk); #1;
      chk("rstb_busy1", mem_req, 1);
      @(posedge clk); #1;
      chk("rstb_busy2", mem_req, 1);
      rst = 1; d_req = 0;
      @(posedge clk); #1;
      chk("rstb_drop", {mem_req, d_done, i_done}, 0);
      rst = 0;
      last_d = 1'b0;
      @(posedge clk); #1;
      chk("rstb_quiet", {mem_req, d_done, i_done}, 0);
      run_txn("after_rst", 1, 32'h8000_0040, 0, 0, 3'd0, 0, 0, 1, 32'h0011_2233);

      // randomized transactions
      for (int k = 0; k < 40; k++) begin
         logic [31:0] ia, da;
         sel = $urandom_range(0, 2);
         ia = {16'h8000, 14'($urandom), ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00};
         da = {16'h8000, 16'($urandom)};
         case ($urandom_range(0, 5))
            0:       stall = 99;
            1:       stall = TO;
            default: stall = $urandom_range(1, 5);
         endcase
         run_txn("rand", sel != 1, ia, sel != 0, 1'($urandom),
                 lens[$urandom_range(0, 7)], da, $urandom, stall, $urandom);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
